// File: rtl/vectored_interrupt_control.sv
// Vectored interrupt controller: synchronises the NMI/IRQ pins, arbitrates RES/NMI/IRQ/BRK at
// instruction boundaries and sequences the two-byte vector fetch address for the core.
module vectored_interrupt_control #(
    parameter int          NUM_IRQ  = 4,
    parameter logic [15:0] VEC_BASE = 16'hFFE0
) (
    input  logic               clk_1,
    input  logic               RES_N,
    input  logic               NMI_N,
    input  logic [NUM_IRQ-1:0] IRQ_N,
    input  logic [NUM_IRQ-1:0] chan_en,
    input  logic [NUM_IRQ-1:0] chan_edge,
    input  logic               interrupt_flag,
    input  logic               rdy,
    input  logic               t0,
    input  logic               op_brk,
    input  logic               vec_fetch,
    output logic               res_g,
    output logic               nmi_g,
    output logic               int_g,
    output logic               brk_g,
    output logic [NUM_IRQ-1:0] in_service,
    output logic [15:0]        vec_addr,
    output logic               brk_done,
    output logic               aic_n
);
    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic [2:0] {ST_RESET, ST_IDLE, ST_SEQ, ST_VEC_LO, ST_VEC_HI} state_t;
    typedef enum logic [2:0] {SRC_NONE, SRC_RES, SRC_NMI, SRC_IRQ, SRC_BRK} src_t;

    state_t           state;
    src_t             src;
    logic [IDX_W-1:0] src_idx;

    logic               nmi_s1, nmi_s2, nmi_prev, nmi_pend, nmi_rearm;
    logic [NUM_IRQ-1:0] irq_s1, irq_s2, irq_prev, edge_pend, irq_rearm;
    logic               nmi_fall, done, in_fetch, irq_hit;
    logic [NUM_IRQ-1:0] irq_fall, pend, clr_mask;
    logic [IDX_W-1:0]   irq_idx;

    // Synchronisers run every cycle; only the edge history behind them honours rdy, so an
    // edge that arrives during a stall is still seen once the core resumes.
    always_ff @(posedge clk_1 or negedge RES_N) begin
        if (!RES_N) begin
            nmi_s1 <= 1'b0;
            nmi_s2 <= 1'b0;
            irq_s1 <= '0;
            irq_s2 <= '0;
        end else begin
            // NOTE: non-blocking assignments keep s1 and s2 as two distinct flop stages.
            nmi_s1 <= NMI_N;
            nmi_s2 <= nmi_s1;
            irq_s1 <= IRQ_N;
            irq_s2 <= irq_s1;
        end
    end

    assign nmi_fall = nmi_prev & ~nmi_s2;
    assign irq_fall = irq_prev & ~irq_s2;
    assign done     = (state == ST_VEC_HI) && rdy;
    assign in_fetch = (state == ST_VEC_LO) || (state == ST_VEC_HI);
    assign clr_mask = (done && src == SRC_IRQ) ? in_service : '0;
    assign pend     = (chan_edge & edge_pend) | (~chan_edge & chan_en & ~irq_s2);
    assign brk_done = done;
    assign aic_n    = ~(res_g | nmi_g | int_g | brk_g);

    // An edge landing after its own vector fetch started is parked in *_rearm so the
    // brk_done clear of the current service does not swallow it.
    always_ff @(posedge clk_1 or negedge RES_N) begin
        if (!RES_N) begin
            nmi_prev  <= 1'b0;
            nmi_pend  <= 1'b0;
            nmi_rearm <= 1'b0;
            irq_prev  <= '0;
            edge_pend <= '0;
            irq_rearm <= '0;
        end else if (rdy) begin
            nmi_prev  <= nmi_s2;
            irq_prev  <= irq_s2;
            nmi_rearm <= done ? 1'b0 : (nmi_rearm | (nmi_fall & in_fetch));
            irq_rearm <= done ? '0 : (irq_rearm | (irq_fall & {NUM_IRQ{in_fetch}}));
            nmi_pend  <= nmi_fall | ((done && src == SRC_NMI) ? nmi_rearm : nmi_pend);
            edge_pend <= chan_en & chan_edge &
                         (irq_fall | (edge_pend & ~clr_mask) | (irq_rearm & clr_mask));
        end
    end

    always_comb begin
        // NOTE: defaults before the loop so every path assigns both outputs (no latch).
        irq_hit = 1'b0;
        irq_idx = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (pend[k] && !interrupt_flag) begin
                irq_hit = 1'b1;
                irq_idx = IDX_W'(k);
            end
        end
    end

    function automatic logic [15:0] vec_of(input src_t s, input logic [IDX_W-1:0] idx);
        case (s)
            SRC_NMI: return 16'hFFFA;
            SRC_BRK: return 16'hFFFE;
            SRC_IRQ: return VEC_BASE + (16'(idx) << 1);
            default: return 16'hFFFC;
        endcase
    endfunction

    always_ff @(posedge clk_1 or negedge RES_N) begin
        if (!RES_N) begin
            state      <= ST_RESET;
            src        <= SRC_RES;
            src_idx    <= '0;
            res_g      <= 1'b1;
            nmi_g      <= 1'b0;
            int_g      <= 1'b0;
            brk_g      <= 1'b0;
            in_service <= '0;
            vec_addr   <= 16'hFFFC;
        end else if (rdy) begin
            case (state)
                ST_RESET: begin
                    if (vec_fetch) begin
                        state    <= ST_VEC_LO;
                        vec_addr <= 16'hFFFC;
                    end
                end
                ST_IDLE: begin
                    if (t0) begin
                        if (nmi_pend) begin
                            state <= ST_SEQ;
                            src   <= SRC_NMI;
                            nmi_g <= 1'b1;
                        end else if (irq_hit) begin
                            state      <= ST_SEQ;
                            src        <= SRC_IRQ;
                            src_idx    <= irq_idx;
                            int_g      <= 1'b1;
                            in_service <= NUM_IRQ'(1) << irq_idx;
                        end else if (op_brk) begin
                            state <= ST_SEQ;
                            src   <= SRC_BRK;
                            brk_g <= 1'b1;
                        end
                    end
                end
                ST_SEQ: begin
                    // A late NMI still wins until the vector fetch begins.
                    if (nmi_pend && src != SRC_NMI) begin
                        src        <= SRC_NMI;
                        nmi_g      <= 1'b1;
                        int_g      <= 1'b0;
                        brk_g      <= 1'b0;
                        in_service <= '0;
                    end
                    if (vec_fetch) begin
                        state    <= ST_VEC_LO;
                        vec_addr <= nmi_pend ? 16'hFFFA : vec_of(src, src_idx);
                    end
                end
                ST_VEC_LO: begin
                    state    <= ST_VEC_HI;
                    vec_addr <= vec_addr + 16'd1;
                end
                ST_VEC_HI: begin
                    state      <= ST_IDLE;
                    src        <= SRC_NONE;
                    res_g      <= 1'b0;
                    nmi_g      <= 1'b0;
                    int_g      <= 1'b0;
                    brk_g      <= 1'b0;
                    in_service <= '0;
                end
                default: state <= ST_RESET;
            endcase
        end
    end

endmodule
